counter_step_sequencer: RTL and testbench
=========================================

Name: counter_step_sequencer

Overview:
Upstream command stage for up_down_counter. Buffers a stream of step magnitudes and drives the counter's b/up/dn/clear inputs one step per cycle. Predicts over/underflow from the counter's q plus the command already in flight, and flips direction or clears the counter so q never wraps. Reports wrap events to the surrounding logic.

Parameters:
WIDTH, 8, data width of steps and of counter q; MAX = 2**WIDTH-1
DEPTH, 4, step FIFO entries (power of 2, >=2)
WCNT_W, 8, width of wrap event counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  allow issuing steps; when low, no step is issued and the FIFO still accepts
clr_req  in  1  synchronous soft clear, one-cycle pulse
step_in  in  WIDTH  step magnitude
step_valid  in  1  step_in valid
step_ready  out  1  FIFO not full
q  in  WIDTH  counter output, fed back
b  out  WIDTH  step to counter, registered
up  out  1  counter increment, registered
dn  out  1  counter decrement, registered
ctr_rst  out  1  counter clear, active-high, registered, 1 cycle
wrap_evt  out  1  1-cycle pulse on direction flip
wrap_cnt  out  WCNT_W  direction flips since reset or clear; wraps modulo 2**WCNT_W
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Counter contract: on each clk edge, q <= 0 if ctr_rst; else q+b if up; else q-b if dn.
- Reset (rst low), applied immediately: b=0, up=dn=ctr_rst=wrap_evt=0, wrap_cnt=0, level=0, dir=UP, state=IDLE. step_ready=1.
- FIFO: push when step_valid and step_ready. step_ready = !full. No push when full, even if a pop happens in the same cycle. No bypass. A step accepted at edge N can be issued at edge N+1 at the earliest. The counter applies it at edge N+2.
- Forwarding: q_eff = 0 if ctr_rst; else q+b if up; else q-b if dn; else q. All checks below use q_eff.
- Fit checks use WIDTH+1-bit arithmetic with head h:
  - fit_up = (q_eff+h <= MAX)
  - fit_dn = (h <= q_eff)
- Default on every cycle unless set below: up=dn=ctr_rst=wrap_evt=0, b=0.
- State IDLE: if en and FIFO non-empty -> RUN. Evaluation happens in the same cycle.
- State RUN, with en=1 and FIFO non-empty:
  - Fits current direction: b=h, up=(dir==UP), dn=(dir==DN), pop.
  - Fails current direction, fits opposite: toggle dir, issue h in the new direction, pop, wrap_evt=1, wrap_cnt+1.
  - Fits neither: ctr_rst=1, no pop, no toggle, go to CLEAR.
- RUN with en=0 or FIFO empty -> IDLE. No outputs are asserted.
- State CLEAR: the single ctr_rst cycle. Next cycle returns to RUN and re-evaluates with q_eff=0.
  - UP then always fits.
  - DN with h>0 flips direction; h=0 fits.
  - No livelock is possible.
- Zero step: always fits; issued and popped as a normal step.
- clr_req, which has priority over everything except rst:
  - flush FIFO (level=0)
  - dir=UP, wrap_cnt=0
  - ctr_rst=1 for 1 cycle, up=dn=0
  - state=IDLE
  - A push in the same cycle is dropped.
- rst low mid-operation: all state returns to reset values at once. An in-flight command is lost.

Decomposition:
- Package counter_seq_pkg:
  - state enum {IDLE, RUN, CLEAR}
  - dir enum {UP, DN}
  - MAX constant
  - helper function returning fit_up/fit_dn
- Sub-module step_fifo: parameterised WIDTH/DEPTH synchronous FIFO with push/pop/full/empty/level, using the same asynchronous active-low rst.

Test Plan:
- Reset, en=1, push 10,20,30 -> b=10,20,30 on consecutive cycles with up=1. q=10,30,60. wrap_cnt=0.
- dir UP, q_eff=250, head 10 -> dn=1, b=10, wrap_evt pulse, wrap_cnt=1, q becomes 240.
- dir UP, q_eff=128, head 200 -> ctr_rst=1 and up=dn=0 for one cycle, step held. Next cycle b=200, up=1, q=200, wrap_cnt unchanged.
- dir DN, q_eff=5, head 5 -> dn=1, q=0, no wrap. Next head 1 -> up=1, wrap_evt, q=1.
- en=0, push 5 values -> step_ready falls after the 4th and level=4. Raise en -> values drain in order, 5th accepted once space frees.
- Mid-run clr_req pulse -> one ctr_rst cycle, level=0, wrap_cnt=0, dir=UP. Mid-run rst low -> all outputs 0 immediately.

Source files
------------

// File: rtl/counter_step_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// counter_seq_pkg
// Shared types and helpers for the counter step sequencer.
//   state_e   : sequencer FSM states (IDLE, RUN, CLEAR)
//   dir_e     : counting direction (UP, DN)
//   fit_t     : result of the over/underflow prediction
//   fit_check : predicts whether a step fits in either direction
// ---------------------------------------------------------------------------
package counter_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned MAX       = (2 ** DEF_WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

    typedef struct packed {
        logic fit_up;
        logic fit_dn;
    } fit_t;

    // Operands are zero-extended to 33 bits so q_eff + h can never wrap
    // for any WIDTH up to 32.
    function automatic fit_t fit_check(input logic [32:0] q_eff,
                                       input logic [32:0] h,
                                       input logic [32:0] max_v);
        fit_t r;
        r.fit_up = ((q_eff + h) <= max_v);
        r.fit_dn = (h <= q_eff);
        return r;
    endfunction

endpackage

// File: rtl/counter_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// counter_step_sequencer_if
// Valid/ready stream of step magnitudes into the sequencer.
//   step_in    : step magnitude (WIDTH bits)
//   step_valid : step_in valid
//   step_ready : sequencer FIFO not full
// master = upstream producer, slave = sequencer.
// ---------------------------------------------------------------------------
interface counter_step_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] step_in;
    logic             step_valid;
    logic             step_ready;

    modport master (output step_in, output step_valid, input step_ready);
    modport slave  (input step_in, input step_valid, output step_ready);
endinterface

// File: rtl/counter_step_sequencer_step_fifo.sv
// ---------------------------------------------------------------------------
// step_fifo
// Synchronous FIFO holding pending step magnitudes.
//   clk, rst   : clock, asynchronous active-low reset
//   flush_i    : synchronous flush, overrides push/pop
//   push_i     : write data_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   data_o     : head entry (valid when !empty_o)
//   full_o, empty_o, level_o : occupancy status
// ---------------------------------------------------------------------------
module step_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    cnt_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (cnt_q == LW'(DEPTH));
    assign empty_o   = (cnt_q == {LW{1'b0}});
    assign level_o   = cnt_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o && !flush_i;
    assign pop_ok_s  = pop_i && !empty_o && !flush_i;

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {LW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_q <= cnt_q + LW'(1'b1);
                2'b01:   cnt_q <= cnt_q - LW'(1'b1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/counter_step_sequencer.sv
// ---------------------------------------------------------------------------
// counter_step_sequencer
// Buffers step magnitudes and drives an up/down counter one step per cycle,
// flipping direction or clearing the counter so its q never wraps.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : allow issuing steps (FIFO accepts regardless)
//   clr_req         : synchronous soft clear pulse
//   step_if (slave) : step_in / step_valid / step_ready stream
//   q               : counter output fed back
//   b, up, dn       : registered step command to the counter
//   ctr_rst         : registered counter clear
//   wrap_evt        : one-cycle pulse on a direction flip
//   wrap_cnt        : direction flips since reset/clear (modulo)
//   level           : FIFO occupancy
// ---------------------------------------------------------------------------
module counter_step_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int WCNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr_req,
    counter_step_sequencer_if.slave  step_if,
    input  logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         b,
    output logic                     up,
    output logic                     dn,
    output logic                     ctr_rst,
    output logic                     wrap_evt,
    output logic [WCNT_W-1:0]        wrap_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam logic [32:0] MAX_V = (33'd1 << WIDTH) - 33'd1;

    state_e              state_q,    state_d;
    dir_e                dir_q,      dir_d;
    dir_e                flip_dir_s;
    logic [WIDTH-1:0]    b_q,        b_d;
    logic                up_q,       up_d;
    logic                dn_q,       dn_d;
    logic                ctr_rst_q,  ctr_rst_d;
    logic                wrap_evt_q, wrap_evt_d;
    logic [WCNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]    head_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                active_s;
    logic [WIDTH-1:0]    q_eff_s;
    fit_t                fit_s;
    logic                cur_fit_s;
    logic                opp_fit_s;

    // A push coinciding with clr_req is dropped along with the flush.
    assign push_s             = step_if.step_valid && !full_s && !clr_req;
    assign step_if.step_ready = !full_s;
    assign active_s           = en && !empty_s;
    assign flip_dir_s         = (dir_q == UP) ? DN : UP;

    step_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clr_req),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (step_if.step_in),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level)
    );

    // Counter value after the command currently on b/up/dn/ctr_rst lands.
    always_comb begin
        q_eff_s = q;
        if (ctr_rst_q) begin
            q_eff_s = {WIDTH{1'b0}};
        end else if (up_q) begin
            q_eff_s = q + b_q;
        end else if (dn_q) begin
            q_eff_s = q - b_q;
        end else begin
            q_eff_s = q;
        end
    end

    // Fit prediction for the head step in current and opposite direction.
    always_comb begin
        fit_s = fit_check(33'(q_eff_s), 33'(head_s), MAX_V);
        if (dir_q == UP) begin
            cur_fit_s = fit_s.fit_up;
            opp_fit_s = fit_s.fit_dn;
        end else begin
            cur_fit_s = fit_s.fit_dn;
            opp_fit_s = fit_s.fit_up;
        end
    end

    // Next-state and command decode.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        b_d        = {WIDTH{1'b0}};
        up_d       = 1'b0;
        dn_d       = 1'b0;
        ctr_rst_d  = 1'b0;
        wrap_evt_d = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        pop_s      = 1'b0;
        if (clr_req) begin
            state_d    = IDLE;
            dir_d      = UP;
            ctr_rst_d  = 1'b1;
            wrap_cnt_d = {WCNT_W{1'b0}};
        end else begin
            case (state_q)
                // All states evaluate the head the same way; IDLE issues in
                // the same cycle, and CLEAR re-evaluates against q_eff=0
                // (forwarded from ctr_rst), where UP always fits.
                IDLE, RUN, CLEAR: begin
                    if (!active_s) begin
                        state_d = IDLE;
                    end else if (cur_fit_s) begin
                        state_d = RUN;
                        b_d     = head_s;
                        up_d    = (dir_q == UP);
                        dn_d    = (dir_q == DN);
                        pop_s   = 1'b1;
                    end else if (opp_fit_s) begin
                        state_d    = RUN;
                        dir_d      = flip_dir_s;
                        b_d        = head_s;
                        up_d       = (flip_dir_s == UP);
                        dn_d       = (flip_dir_s == DN);
                        pop_s      = 1'b1;
                        wrap_evt_d = 1'b1;
                        wrap_cnt_d = wrap_cnt_q + WCNT_W'(1'b1);
                    end else begin
                        // Step fits neither way: clear and hold the step.
                        state_d   = CLEAR;
                        ctr_rst_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered command outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dir_q      <= UP;
            b_q        <= {WIDTH{1'b0}};
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            ctr_rst_q  <= 1'b0;
            wrap_evt_q <= 1'b0;
            wrap_cnt_q <= {WCNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            b_q        <= b_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            ctr_rst_q  <= ctr_rst_d;
            wrap_evt_q <= wrap_evt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign b        = b_q;
    assign up       = up_q;
    assign dn       = dn_q;
    assign ctr_rst  = ctr_rst_q;
    assign wrap_evt = wrap_evt_q;
    assign wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_counter_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_step_sequencer
// Directed bench: a behavioural up_down_counter closes the q loop; each step
// drives inputs just after a rising edge and checks registered outputs there.
// ---------------------------------------------------------------------------
module tb_counter_step_sequencer;
    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_req;
    logic [7:0] q;
    logic [7:0] b;
    logic       up;
    logic       dn;
    logic       ctr_rst;
    logic       wrap_evt;
    logic [7:0] wrap_cnt;
    logic [2:0] level;

    int total;
    int bad;

    counter_step_sequencer_if #(.WIDTH(8)) sif ();

    counter_step_sequencer #(
        .WIDTH  (8),
        .DEPTH  (4),
        .WCNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr_req  (clr_req),
        .step_if  (sif),
        .q        (q),
        .b        (b),
        .up       (up),
        .dn       (dn),
        .ctr_rst  (ctr_rst),
        .wrap_evt (wrap_evt),
        .wrap_cnt (wrap_cnt),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream up_down_counter behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 8'd0;
        end else if (ctr_rst) begin
            q <= 8'd0;
        end else if (up) begin
            q <= q + b;
        end else if (dn) begin
            q <= q - b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        en             = 1'b0;
        clr_req        = 1'b0;
        sif.step_in    = 8'd0;
        sif.step_valid = 1'b0;
        #12;
        check("rst_b",        32'(b),              32'd0);
        check("rst_up",       32'(up),             32'd0);
        check("rst_ctr_rst",  32'(ctr_rst),        32'd0);
        check("rst_wrap_cnt", 32'(wrap_cnt),       32'd0);
        check("rst_level",    32'(level),          32'd0);
        check("rst_ready",    32'(sif.step_ready), 32'd1);
        rst = 1'b1;

        // Steps 10,20,30 issued on consecutive cycles, counting up.
        en = 1'b1; sif.step_valid = 1'b1; sif.step_in = 8'd10;
        tick();
        sif.step_in = 8'd20;
        tick();
        check("t1_b10",  32'(b),  32'd10);
        check("t1_up10", 32'(up), 32'd1);
        sif.step_in = 8'd30;
        tick();
        check("t1_b20", 32'(b), 32'd20);
        check("t1_q10", 32'(q), 32'd10);
        sif.step_valid = 1'b0;
        tick();
        check("t1_b30", 32'(b), 32'd30);
        check("t1_q30", 32'(q), 32'd30);
        tick();
        check("t1_q60",   32'(q),        32'd60);
        check("t1_idle",  32'(up),       32'd0);
        check("t1_wcnt",  32'(wrap_cnt), 32'd0);
        check("t1_level", 32'(level),    32'd0);

        // q_eff=250 with head 10 while UP: flip to DN.
        sif.step_valid = 1'b1; sif.step_in = 8'd190;
        tick();
        sif.step_in = 8'd10;
        tick();
        check("t2_b190", 32'(b), 32'd190);
        sif.step_valid = 1'b0;
        tick();
        check("t2_dn",    32'(dn),       32'd1);
        check("t2_b10",   32'(b),        32'd10);
        check("t2_wevt",  32'(wrap_evt), 32'd1);
        check("t2_wcnt",  32'(wrap_cnt), 32'd1);
        check("t2_q250",  32'(q),        32'd250);
        tick();
        check("t2_q240",  32'(q),        32'd240);
        check("t2_wevt0", 32'(wrap_evt), 32'd0);

        // Soft clear brings dir back to UP, q to 0, wrap_cnt to 0.
        clr_req = 1'b1;
        tick();
        check("c1_ctr_rst", 32'(ctr_rst),  32'd1);
        check("c1_wcnt",    32'(wrap_cnt), 32'd0);
        clr_req = 1'b0;
        tick();
        check("c1_q0",      32'(q),        32'd0);
        check("c1_ctr_rst0", 32'(ctr_rst), 32'd0);

        // q_eff=128 with head 200 while UP: fits neither, forced clear.
        sif.step_valid = 1'b1; sif.step_in = 8'd128;
        tick();
        sif.step_in = 8'd200;
        tick();
        check("t3_b128", 32'(b), 32'd128);
        sif.step_valid = 1'b0;
        tick();
        check("t3_ctr_rst", 32'(ctr_rst), 32'd1);
        check("t3_up0",     32'(up),      32'd0);
        check("t3_dn0",     32'(dn),      32'd0);
        check("t3_held",    32'(level),   32'd1);
        check("t3_q128",    32'(q),       32'd128);
        tick();
        check("t3_b200",    32'(b),        32'd200);
        check("t3_up1",     32'(up),       32'd1);
        check("t3_ctr0",    32'(ctr_rst),  32'd0);
        check("t3_q0",      32'(q),        32'd0);
        check("t3_wcnt",    32'(wrap_cnt), 32'd0);
        tick();
        check("t3_q200",    32'(q),        32'd200);

        // 60 flips to DN (q=140), 135 -> q=5, 5 -> q=0, 1 flips to UP.
        sif.step_valid = 1'b1; sif.step_in = 8'd60;
        tick();
        sif.step_in = 8'd135;
        tick();
        check("t4_dn60",   32'(dn),       32'd1);
        check("t4_wevt60", 32'(wrap_evt), 32'd1);
        check("t4_wcnt1",  32'(wrap_cnt), 32'd1);
        sif.step_in = 8'd5;
        tick();
        check("t4_b135",   32'(b),        32'd135);
        check("t4_q140",   32'(q),        32'd140);
        sif.step_in = 8'd1;
        tick();
        check("t4_dn5",    32'(dn),       32'd1);
        check("t4_b5",     32'(b),        32'd5);
        check("t4_nowrap", 32'(wrap_evt), 32'd0);
        check("t4_q5",     32'(q),        32'd5);
        sif.step_valid = 1'b0;
        tick();
        check("t4_up1",    32'(up),       32'd1);
        check("t4_b1",     32'(b),        32'd1);
        check("t4_wevt1",  32'(wrap_evt), 32'd1);
        check("t4_wcnt2",  32'(wrap_cnt), 32'd2);
        check("t4_q0",     32'(q),        32'd0);
        tick();
        check("t4_qone",   32'(q),        32'd1);

        // en=0: FIFO fills to 4, 5th held until a pop frees space.
        en = 1'b0; sif.step_valid = 1'b1; sif.step_in = 8'd2;
        tick();
        sif.step_in = 8'd3;
        tick();
        sif.step_in = 8'd4;
        tick();
        sif.step_in = 8'd5;
        tick();
        check("t5_level4", 32'(level),          32'd4);
        check("t5_full",   32'(sif.step_ready), 32'd0);
        sif.step_in = 8'd6;
        tick();
        check("t5_hold_lv", 32'(level), 32'd4);
        check("t5_no_issue", 32'(up),   32'd0);
        en = 1'b1;
        tick();
        check("t5_b2",     32'(b),              32'd2);
        check("t5_lv3",    32'(level),          32'd3);
        check("t5_ready",  32'(sif.step_ready), 32'd1);
        tick();
        check("t5_b3",     32'(b),     32'd3);
        check("t5_lv3b",   32'(level), 32'd3);
        sif.step_valid = 1'b0;
        tick();
        check("t5_b4",     32'(b),     32'd4);
        tick();
        check("t5_b5",     32'(b),     32'd5);
        tick();
        check("t5_b6",     32'(b),     32'd6);
        check("t5_lv0",    32'(level), 32'd0);
        tick();
        check("t5_q21",    32'(q),     32'd21);

        // Mid-run clr_req with a partly full FIFO and a same-cycle push.
        en = 1'b0; sif.step_valid = 1'b1; sif.step_in = 8'd7;
        tick();
        sif.step_in = 8'd8;
        tick();
        sif.step_in = 8'd9;
        tick();
        check("t6_lv3", 32'(level), 32'd3);
        clr_req = 1'b1; en = 1'b1; sif.step_in = 8'd50;
        tick();
        check("t6_ctr_rst", 32'(ctr_rst),  32'd1);
        check("t6_up0",     32'(up),       32'd0);
        check("t6_b0",      32'(b),        32'd0);
        check("t6_lv0",     32'(level),    32'd0);
        check("t6_wcnt0",   32'(wrap_cnt), 32'd0);
        clr_req = 1'b0; sif.step_valid = 1'b0;
        tick();
        check("t6_q0",      32'(q),        32'd0);
        check("t6_lv_drop", 32'(level),    32'd0);
        sif.step_valid = 1'b1; sif.step_in = 8'd3;
        tick();
        sif.step_valid = 1'b0;
        tick();
        check("t6_dir_up",  32'(up),       32'd1);
        check("t6_b3",      32'(b),        32'd3);
        check("t6_nowrap",  32'(wrap_evt), 32'd0);

        // Asynchronous reset in the middle of a run.
        sif.step_valid = 1'b1; sif.step_in = 8'd10;
        tick();
        tick();
        check("t7_up_pre",  32'(up),    32'd1);
        check("t7_lv_pre",  32'(level), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t7_b0",      32'(b),              32'd0);
        check("t7_up0",     32'(up),             32'd0);
        check("t7_lv0",     32'(level),          32'd0);
        check("t7_ready",   32'(sif.step_ready), 32'd1);
        check("t7_ctr_rst", 32'(ctr_rst),        32'd0);
        sif.step_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
